// File: rtl/mp64_timer_mc_pkg.sv
// ---------------------------------------------------------------------------
// mp64_timer_mc_pkg
//   Shared constants for the multi-channel system timer: register map
//   offsets, channel window geometry, CTRL bit positions and the CTRL
//   register layout.
//   No ports (package).
// ---------------------------------------------------------------------------
package mp64_timer_mc_pkg;

   // Global registers in the 0x00-0x0F window
   localparam logic [7:0] TMR_PRESCALE  = 8'h00;   // 0x00 low byte, 0x01 high byte
   localparam logic [7:0] TMR_IRQ_PEND  = 8'h02;

   // Channel i lives at TMR_CH_BASE + i*TMR_CH_STRIDE
   localparam logic [7:0] TMR_CH_STRIDE = 8'h10;
   localparam logic [7:0] TMR_CH_BASE   = 8'h10;

   // Offsets inside a channel window
   localparam logic [3:0] TMR_COUNT     = 4'h0;    // +0..+3
   localparam logic [3:0] TMR_CMP       = 4'h4;    // +4..+7
   localparam logic [3:0] TMR_CTRL      = 4'h8;
   localparam logic [3:0] TMR_STATUS    = 4'h9;

   // CTRL bit indices
   localparam int TMR_CTRL_EN      = 0;
   localparam int TMR_CTRL_IRQ_EN  = 1;
   localparam int TMR_CTRL_RELOAD  = 2;
   localparam int TMR_CTRL_ONESHOT = 3;

   // CTRL register image, field order matches the bit indices above
   typedef struct packed {
      logic oneshot;
      logic reload;
      logic irq_en;
      logic en;
   } tmr_ctrl_t;

endpackage

// File: rtl/mp64_timer_mc_if.sv
// ---------------------------------------------------------------------------
// mp64_timer_mc_if
//   8-bit MMIO peripheral bus as seen by the timer block.
//   req   : one-cycle access strobe        (master -> slave)
//   addr  : byte offset in the timer block (master -> slave)
//   wdata : write byte                     (master -> slave)
//   wen   : 1 = write, 0 = read            (master -> slave)
//   rdata : registered read byte           (slave -> master)
//   ack   : one-cycle acknowledge          (slave -> master)
// ---------------------------------------------------------------------------
interface mp64_timer_mc_if;
   logic       req;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       wen;
   logic [7:0] rdata;
   logic       ack;

   modport master (output req, addr, wdata, wen, input  rdata, ack);
   modport slave  (input  req, addr, wdata, wen, output rdata, ack);
endinterface

// File: rtl/mp64_timer_mc_ch.sv
// ---------------------------------------------------------------------------
// mp64_timer_mc_ch
//   One timer channel: counter, compare, CTRL, match flag and the snapshot
//   used for tear-free multi-byte COUNT reads.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_tick         : shared prescaler tick
//   i_wr_cnt[k]    : write strobe for COUNT byte k
//   i_wr_cmp[k]    : write strobe for CMP byte k
//   i_wr_ctrl      : write strobe for CTRL
//   i_wr_status    : write strobe for STATUS (bit0 is W1C)
//   i_rd0          : read strobe for COUNT+0 (latches the snapshot)
//   i_wdata        : write byte
//   o_rbytes[n]    : read value of window offset n (unmapped offsets are 0)
//   o_irq          : match flag qualified by IRQ_EN
// ---------------------------------------------------------------------------
module mp64_timer_mc_ch
   import mp64_timer_mc_pkg::*;
#(
   parameter  int CNT_W = 32,
   localparam int NB    = CNT_W / 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic [NB-1:0]    i_wr_cnt,
   input  logic [NB-1:0]    i_wr_cmp,
   input  logic             i_wr_ctrl,
   input  logic             i_wr_status,
   input  logic             i_rd0,
   input  logic [7:0]       i_wdata,
   output logic [15:0][7:0] o_rbytes,
   output logic             o_irq
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_cmp;
   logic [CNT_W-1:8] r_snap;     // byte 0 is always read live, so it is not kept
   tmr_ctrl_t        r_ctrl;
   logic             r_flag;

   logic [CNT_W-1:0] w_count_wr;
   logic [CNT_W-1:0] w_cmp_wr;
   logic             w_cnt_wr;
   logic             w_match;
   logic [3:0][7:0]  w_cnt_rd;
   logic [3:0][7:0]  w_cmp_rd;

   genvar gi;
   generate
      // Byte-merge of the write data into the current register value
      for (gi = 0; gi < NB; gi++) begin : g_wr_byte
         assign w_count_wr[gi*8 +: 8] = i_wr_cnt[gi] ? i_wdata : r_count[gi*8 +: 8];
         assign w_cmp_wr[gi*8 +: 8]   = i_wr_cmp[gi] ? i_wdata : r_cmp[gi*8 +: 8];
      end

      // Read bytes: COUNT+0 is live, COUNT+1.. come from the snapshot taken
      // by the last COUNT+0 read; bytes beyond the counter width read 0.
      for (gi = 0; gi < 4; gi++) begin : g_rd_byte
         if (gi == 0) begin : g_live
            assign w_cnt_rd[gi] = r_count[7:0];
            assign w_cmp_rd[gi] = r_cmp[7:0];
         end else if (gi < NB) begin : g_snap
            assign w_cnt_rd[gi] = r_snap[gi*8 +: 8];
            assign w_cmp_rd[gi] = r_cmp[gi*8 +: 8];
         end else begin : g_zero
            assign w_cnt_rd[gi] = 8'h00;
            assign w_cmp_rd[gi] = 8'h00;
         end
      end
   endgenerate

   assign w_cnt_wr = |i_wr_cnt;

   // A COUNT write in the same cycle as a tick suppresses both the increment
   // and the compare; CMP == 0 never matches.
   assign w_match = i_tick & r_ctrl.en & ~w_cnt_wr
                  & (r_count == r_cmp) & (r_cmp != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_cmp   <= '0;
         r_snap  <= '0;
         r_ctrl  <= '0;
         r_flag  <= 1'b0;
      end else begin
         if (w_cnt_wr) begin
            r_count <= w_count_wr;
         end else if (i_tick && r_ctrl.en) begin
            r_count <= (w_match && r_ctrl.reload) ? '0 : r_count + CNT_W'(1);
         end

         if (|i_wr_cmp) begin
            r_cmp <= w_cmp_wr;
         end

         // A software CTRL write takes precedence over the one-shot disable
         if (i_wr_ctrl) begin
            r_ctrl <= tmr_ctrl_t'(i_wdata[3:0]);
         end else if (w_match && r_ctrl.oneshot) begin
            r_ctrl.en <= 1'b0;
         end

         // Set wins over a simultaneous W1C
         if (w_match) begin
            r_flag <= 1'b1;
         end else if (i_wr_status && i_wdata[0]) begin
            r_flag <= 1'b0;
         end

         if (i_rd0) begin
            r_snap <= r_count[CNT_W-1:8];
         end
      end
   end

   // Window layout: bytes 15..10 unused, 9 STATUS, 8 CTRL, 7..4 CMP, 3..0 COUNT
   assign o_rbytes = {48'h0, {7'h0, r_flag}, {4'h0, r_ctrl}, w_cmp_rd, w_cnt_rd};
   assign o_irq    = r_flag & r_ctrl.irq_en;

endmodule

// File: rtl/mp64_timer_mc.sv
// ---------------------------------------------------------------------------
// mp64_timer_mc
//   Multi-channel system timer on the 8-bit MMIO bus: shared prescaler,
//   N_CH independent channels, register decode, registered read path and
//   interrupt aggregation. Channel 0 is the scheduler tick.
//   clk        : system clock
//   rst_n      : asynchronous reset, active low
//   bus        : MMIO slave port (req/addr/wdata/wen in, rdata/ack out)
//   o_irq      : per-channel interrupt (flag & IRQ_EN)
//   o_irq_any  : OR of o_irq
// ---------------------------------------------------------------------------
module mp64_timer_mc
   import mp64_timer_mc_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   parameter int PRE_W = 16
)(
   input  logic            clk,
   input  logic            rst_n,
   mp64_timer_mc_if.slave  bus,
   output logic [N_CH-1:0] o_irq,
   output logic            o_irq_any
);

   localparam int NB = CNT_W / 8;

   logic [PRE_W-1:0]  r_prescale;
   logic [PRE_W-1:0]  r_pre_cnt;
   logic [7:0]        r_rdata;
   logic              r_ack;

   logic              w_tick;
   logic              w_pre_wr;
   logic [15:0]       w_pre16;
   logic [15:0]       w_pre16_wr;
   logic [3:0]        w_win;
   logic [3:0]        w_off;
   logic [3:0]        w_ch_idx;
   logic [7:0]        w_rd_byte;
   logic [15:0][7:0]  w_ch_rbytes [N_CH];

   assign w_win    = bus.addr[7:4];
   assign w_off    = bus.addr[3:0];
   // Window 0 maps to index 15, which never selects a channel
   assign w_ch_idx = w_win - TMR_CH_BASE[7:4];

   // ---------------- prescaler ----------------
   assign w_tick     = (r_pre_cnt == r_prescale);
   assign w_pre16    = 16'(r_prescale);
   assign w_pre_wr   = bus.req & bus.wen & (bus.addr[7:1] == TMR_PRESCALE[7:1]);
   assign w_pre16_wr = bus.addr[0] ? {bus.wdata, w_pre16[7:0]}
                                   : {w_pre16[15:8], bus.wdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale <= '0;
         r_pre_cnt  <= '0;
      end else if (w_pre_wr) begin
         // New divider starts a fresh full period
         r_prescale <= PRE_W'(w_pre16_wr);
         r_pre_cnt  <= '0;
      end else if (w_tick) begin
         r_pre_cnt  <= '0;
      end else begin
         r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
      end
   end

   // ---------------- channels ----------------
   genvar gi, gk;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic          w_sel;
         logic          w_wr;
         logic          w_rd0;
         logic [NB-1:0] w_wr_cnt;
         logic [NB-1:0] w_wr_cmp;

         assign w_sel = bus.req & (w_ch_idx == 4'(gi));
         assign w_wr  = w_sel & bus.wen;
         assign w_rd0 = w_sel & ~bus.wen & (w_off == TMR_COUNT);

         // Only bytes inside the counter width get strobes; others are ignored
         for (gk = 0; gk < NB; gk++) begin : g_byte
            assign w_wr_cnt[gk] = w_wr & (w_off == TMR_COUNT + 4'(gk));
            assign w_wr_cmp[gk] = w_wr & (w_off == TMR_CMP + 4'(gk));
         end

         mp64_timer_mc_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_tick      (w_tick),
            .i_wr_cnt    (w_wr_cnt),
            .i_wr_cmp    (w_wr_cmp),
            .i_wr_ctrl   (w_wr & (w_off == TMR_CTRL)),
            .i_wr_status (w_wr & (w_off == TMR_STATUS)),
            .i_rd0       (w_rd0),
            .i_wdata     (bus.wdata),
            .o_rbytes    (w_ch_rbytes[gi]),
            .o_irq       (o_irq[gi])
         );
      end
   endgenerate

   assign o_irq_any = |o_irq;

   // ---------------- read mux ----------------
   always_comb begin
      w_rd_byte = 8'h00;
      if (w_win == 4'h0) begin
         if (bus.addr[7:1] == TMR_PRESCALE[7:1]) begin
            w_rd_byte = bus.addr[0] ? w_pre16[15:8] : w_pre16[7:0];
         end else if (bus.addr == TMR_IRQ_PEND) begin
            w_rd_byte = 8'(o_irq);
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_ch_idx == 4'(c)) begin
               w_rd_byte = w_ch_rbytes[c][w_off];
            end
         end
      end
   end

   // Every access is acknowledged one cycle later; writes leave rdata alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 8'h00;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= bus.req;
         if (bus.req && !bus.wen) begin
            r_rdata <= w_rd_byte;
         end
      end
   end

   assign bus.rdata = r_rdata;
   assign bus.ack   = r_ack;

endmodule

// File: tb/tb_mp64_timer_mc.sv
// ---------------------------------------------------------------------------
// tb_mp64_timer_mc
//   Directed bench: a 4-channel 32-bit timer (u_dut) and a 2-channel 16-bit
//   timer (u_dut16) share one bus driver; tb_sel picks the target.
//   Bus tasks are entered on a falling edge and hold req across exactly one
//   rising edge, so cycle numbering below is in rising edges.
// ---------------------------------------------------------------------------
module tb_mp64_timer_mc;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mp64_timer_mc_if bus_a ();
   mp64_timer_mc_if bus_b ();

   logic       tb_sel = 1'b0, tb_req = 1'b0, tb_wen = 1'b0;
   logic [7:0] tb_addr = 8'h00, tb_wdata = 8'h00;

   assign bus_a.req   = tb_req & ~tb_sel;
   assign bus_a.wen   = tb_wen;
   assign bus_a.addr  = tb_addr;
   assign bus_a.wdata = tb_wdata;
   assign bus_b.req   = tb_req & tb_sel;
   assign bus_b.wen   = tb_wen;
   assign bus_b.addr  = tb_addr;
   assign bus_b.wdata = tb_wdata;

   logic [3:0] irq_a;
   logic       irq_any_a;
   logic [1:0] irq_b;
   logic       irq_any_b;

   mp64_timer_mc #(.N_CH(4), .CNT_W(32), .PRE_W(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_a),
      .o_irq     (irq_a),
      .o_irq_any (irq_any_a)
   );

   mp64_timer_mc #(.N_CH(2), .CNT_W(16), .PRE_W(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_b),
      .o_irq     (irq_b),
      .o_irq_any (irq_any_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      tb_req = 1'b1; tb_wen = 1'b1; tb_addr = a; tb_wdata = d;
      @(negedge clk);
      tb_req = 1'b0; tb_wen = 1'b0;
      $display("[%0t] dut%0d wr %02h <= %02h", $time, tb_sel, a, d);
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
      tb_req = 1'b1; tb_wen = 1'b0; tb_addr = a;
      @(negedge clk);
      tb_req = 1'b0;
      d = tb_sel ? bus_b.rdata : bus_a.rdata;
      $display("[%0t] dut%0d rd %02h -> %02h", $time, tb_sel, a, d);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_rd(a, d);
      chk(tag, 32'(d), 32'(exp));
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_rdata",   32'(bus_a.rdata), 32'h0);
      chk("rst_ack",     32'(bus_a.ack),   32'h0);
      chk("rst_irq",     32'(irq_a),       32'h0);
      chk("rst_irq_any", 32'(irq_any_a),   32'h0);
      rd_chk("rst_prescale", 8'h00, 8'h00);
      chk("ack_hi", 32'(bus_a.ack), 32'h1);
      idle(1);
      chk("ack_lo", 32'(bus_a.ack), 32'h0);

      // ---------------- 1: ch0 auto-reload, PRESCALE=0 ----------------
      bus_wr(8'h14, 8'h05);
      bus_wr(8'h18, 8'h07);                     // EN at edge E0
      idle(5);                                  // count reaches 5 at E5
      chk("t1_irq_pre", 32'(irq_a), 32'h0);
      idle(1);                                  // match at E6
      chk("t1_irq",     32'(irq_a),     32'h1);
      chk("t1_irq_any", 32'(irq_any_a), 32'h1);
      rd_chk("t1_reload_cnt", 8'h10, 8'h00);    // reloaded to 0 by the match
      bus_wr(8'h19, 8'h01);                     // W1C
      chk("t1_w1c_irq",     32'(irq_a),     32'h0);
      chk("t1_w1c_irq_any", 32'(irq_any_a), 32'h0);
      bus_wr(8'h18, 8'h00);                     // ch0 count freezes at 3

      // ---------------- 2: PRESCALE=3, ch1 ----------------
      bus_wr(8'h24, 8'h02);
      bus_wr(8'h00, 8'h03);                     // edge P, ticks at P+4, P+8, ...
      bus_wr(8'h28, 8'h01);                     // EN at P+1
      idle(5);
      rd_chk("t2_cnt_p7",  8'h20, 8'h01);
      rd_chk("t2_cnt_p8",  8'h20, 8'h01);
      rd_chk("t2_cnt_p9",  8'h20, 8'h02);
      rd_chk("t2_flag_p10", 8'h29, 8'h00);
      idle(2);                                  // match at P+12
      rd_chk("t2_flag_p13", 8'h29, 8'h01);
      rd_chk("t2_cnt_p14", 8'h20, 8'h03);
      chk("t2_no_irq_en", 32'(irq_a), 32'h0);
      bus_wr(8'h00, 8'h03);                     // P+15: restart the period
      idle(1);
      rd_chk("t2_restart_p17", 8'h20, 8'h03);
      idle(1);
      rd_chk("t2_restart_p19", 8'h20, 8'h03);
      rd_chk("t2_restart_p20", 8'h20, 8'h04);
      rd_chk("t2_pre_lo", 8'h00, 8'h03);
      rd_chk("t2_pre_hi", 8'h01, 8'h00);
      bus_wr(8'h28, 8'h00);
      chk("wr_ack",        32'(bus_a.ack),   32'h1);
      chk("wr_rdata_hold", 32'(bus_a.rdata), 32'h0);
      bus_wr(8'h29, 8'h01);
      bus_wr(8'h00, 8'h00);
      rd_chk("t2_flag_clr", 8'h29, 8'h00);

      // ---------------- 3: ch2 one-shot ----------------
      bus_wr(8'h34, 8'h03);
      bus_wr(8'h38, 8'h0B);
      idle(10);
      rd_chk("t3_ctrl", 8'h38, 8'h0A);
      rd_chk("t3_cnt",  8'h30, 8'h04);
      chk("t3_irq",     32'(irq_a),     32'h4);
      chk("t3_irq_any", 32'(irq_any_a), 32'h1);
      idle(10);
      rd_chk("t3_frozen", 8'h30, 8'h04);

      // ---------------- 5: tear-free read, write vs tick (ch3) ----------------
      bus_wr(8'h40, 8'hFF);
      bus_wr(8'h41, 8'h00);
      bus_wr(8'h42, 8'h00);
      bus_wr(8'h43, 8'h00);
      bus_wr(8'h48, 8'h01);                     // EN at edge A
      rd_chk("t5_b0",  8'h40, 8'hFF);           // snap = 0x000000FF
      idle(300);
      rd_chk("t5_b1",  8'h41, 8'h00);
      rd_chk("t5_b2",  8'h42, 8'h00);
      rd_chk("t5_b3",  8'h43, 8'h00);
      rd_chk("t5_live_b0", 8'h40, 8'h2F);       // 0xFF + 304 = 0x22F
      rd_chk("t5_live_b1", 8'h41, 8'h02);
      bus_wr(8'h40, 8'h10);                     // 0x231 -> 0x210, no increment
      rd_chk("t5_wr_tick", 8'h40, 8'h10);
      bus_wr(8'h48, 8'h00);

      // ---------------- 4: 16-bit build wrap ----------------
      tb_sel = 1'b1;
      bus_wr(8'h10, 8'hFF);
      bus_wr(8'h11, 8'hFF);
      bus_wr(8'h12, 8'h55);                     // beyond width: ignored
      bus_wr(8'h16, 8'h77);                     // beyond width: ignored
      bus_wr(8'h18, 8'h03);
      rd_chk("t4_ffff",   8'h10, 8'hFF);
      rd_chk("t4_wrap",   8'h10, 8'h00);
      rd_chk("t4_wrap_b1", 8'h11, 8'h00);
      rd_chk("t4_no_flag", 8'h19, 8'h00);
      chk("t4_irq", 32'({irq_any_b, irq_b}), 32'h0);
      rd_chk("t4_cnt_b2", 8'h12, 8'h00);
      rd_chk("t4_cmp_b2", 8'h16, 8'h00);
      rd_chk("t4_ch2_absent", 8'h38, 8'h00);
      tb_sel = 1'b0;

      // ---------------- 6: set beats W1C, unmapped, reset ----------------
      bus_wr(8'h14, 8'h20);
      bus_wr(8'h10, 8'h1E);
      bus_wr(8'h18, 8'h03);                     // EN at B, match at B+3
      idle(2);
      bus_wr(8'h19, 8'h01);                     // W1C at B+3
      chk("t6_set_wins", 32'(irq_a), 32'h5);
      bus_wr(8'h19, 8'h01);
      chk("t6_w1c", 32'(irq_a), 32'h4);
      rd_chk("t6_irq_pend", 8'h02, 8'h04);
      rd_chk("t6_unmapped_03", 8'h03, 8'h00);
      rd_chk("t6_unmapped_1a", 8'h1A, 8'h00);
      bus_wr(8'h58, 8'h01);
      rd_chk("t6_ch4_ctrl", 8'h58, 8'h00);

      bus_wr(8'h00, 8'h07);
      tb_req = 1'b1; tb_wen = 1'b0; tb_addr = 8'h38;
      @(posedge clk); #2;
      chk("t6_ack_pre_rst",   32'(bus_a.ack),   32'h1);
      chk("t6_rdata_pre_rst", 32'(bus_a.rdata), 32'h0A);
      rst_n = 1'b0; tb_req = 1'b0;
      #1;
      chk("t6_rst_ack",     32'(bus_a.ack),   32'h0);
      chk("t6_rst_rdata",   32'(bus_a.rdata), 32'h0);
      chk("t6_rst_irq",     32'(irq_a),       32'h0);
      chk("t6_rst_irq_any", 32'(irq_any_a),   32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rd_chk("t6_rst_pre",   8'h00, 8'h00);
      rd_chk("t6_rst_ctrl2", 8'h38, 8'h00);
      rd_chk("t6_rst_cnt2",  8'h30, 8'h00);
      rd_chk("t6_rst_cmp0",  8'h14, 8'h00);
      rd_chk("t6_rst_stat2", 8'h39, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
